// File: rtl/sisc_pkg.sv
// -----------------------------------------------------------------------------
// sisc_pkg
// Shared definitions for the SISC multi-cycle controller: the FSM state
// encoding, opcode constants, PC-source and writeback-source codes, and the
// default mm value that selects the immediate operand.
// No ports (package).
// -----------------------------------------------------------------------------
package sisc_pkg;

   typedef enum logic [3:0] {
      S_START0,
      S_START1,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_WB2,
      S_HALT
   } state_t;

   // Opcodes (4-bit; the controller zero-extends or truncates to OP_W)
   localparam logic [3:0] OPC_NOOP = 4'd0;
   localparam logic [3:0] OPC_LOD  = 4'd1;
   localparam logic [3:0] OPC_STR  = 4'd2;
   localparam logic [3:0] OPC_SWP  = 4'd3;
   localparam logic [3:0] OPC_BRA  = 4'd4;
   localparam logic [3:0] OPC_BRR  = 4'd5;
   localparam logic [3:0] OPC_BNE  = 4'd6;
   localparam logic [3:0] OPC_BNR  = 4'd7;
   localparam logic [3:0] OPC_ALU  = 4'd8;
   localparam logic [3:0] OPC_HLT  = 4'd15;

   // PC source select
   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_ABS = 2'd1;
   localparam logic [1:0] PC_REL = 2'd2;

   // Writeback source select
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_SWP = 2'd2;

   // mm value that selects the immediate ALU operand
   localparam int IMM_MM_DEF = 8;

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// -----------------------------------------------------------------------------
// sisc_ctrl_mc_if
// Bundle between the SISC controller and the datapath/memory.
//   opcode, mm, stat, mem_rdy            : datapath/memory -> controller
//   mem_req, dm_we, ir_load, pc_write,
//   pc_sel, rf_we, alu_op, wb_sel,
//   halted, illegal                      : controller -> datapath/memory
// Modports: master = controller side, slave = datapath/memory side.
// -----------------------------------------------------------------------------
interface sisc_ctrl_mc_if #(
   parameter int OP_W   = 4,
   parameter int STAT_W = 4
);
   logic [OP_W-1:0]   opcode;
   logic [STAT_W-1:0] mm;
   logic [STAT_W-1:0] stat;
   logic              mem_rdy;

   logic              mem_req;
   logic              dm_we;
   logic              ir_load;
   logic              pc_write;
   logic [1:0]        pc_sel;
   logic              rf_we;
   logic [1:0]        alu_op;
   logic [1:0]        wb_sel;
   logic              halted;
   logic              illegal;

   modport master (
      input  opcode, mm, stat, mem_rdy,
      output mem_req, dm_we, ir_load, pc_write, pc_sel,
             rf_we, alu_op, wb_sel, halted, illegal
   );

   modport slave (
      output opcode, mm, stat, mem_rdy,
      input  mem_req, dm_we, ir_load, pc_write, pc_sel,
             rf_we, alu_op, wb_sel, halted, illegal
   );
endinterface

// File: rtl/sisc_br_cond.sv
// -----------------------------------------------------------------------------
// sisc_br_cond
// Branch condition evaluator. BRA/BRR are taken when any masked status bit is
// set; BNE/BNR are taken when no masked status bit is set. Any other opcode
// reports not-taken.
// Ports:
//   opcode (in, OP_W)   : current instruction opcode
//   mm     (in, STAT_W) : condition mask
//   stat   (in, STAT_W) : status register
//   taken  (out, 1)     : branch condition satisfied
// -----------------------------------------------------------------------------
module sisc_br_cond
   import sisc_pkg::*;
#(
   parameter int OP_W   = 4,
   parameter int STAT_W = 4
)(
   input  logic [OP_W-1:0]   opcode,
   input  logic [STAT_W-1:0] mm,
   input  logic [STAT_W-1:0] stat,
   output logic              taken
);

   logic [STAT_W-1:0] hit;
   logic              any_hit;

   genvar gi;
   generate
      for (gi = 0; gi < STAT_W; gi++) begin : g_hit
         assign hit[gi] = stat[gi] & mm[gi];
      end
   endgenerate

   assign any_hit = |hit;

   always_comb begin
      taken = 1'b0;
      if (opcode == OP_W'(OPC_BRA) || opcode == OP_W'(OPC_BRR))
         taken = any_hit;
      else if (opcode == OP_W'(OPC_BNE) || opcode == OP_W'(OPC_BNR))
         taken = ~any_hit;
   end

endmodule

// File: rtl/sisc_ctrl_mc.sv
// -----------------------------------------------------------------------------
// sisc_ctrl_mc
// Multi-cycle control unit for the SISC processor. A Moore/Mealy FSM
// (START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM/WB/WB2, HALT) whose
// outputs are combinational from the present state and opcode/mm/stat/mem_rdy.
// Ports:
//   clk   (in)  : system clock, rising edge
//   rst_f (in)  : synchronous active-high reset, forces START0
//   bus         : sisc_ctrl_mc_if.master (opcode, mm, stat, mem_rdy in;
//                 mem_req, dm_we, ir_load, pc_write, pc_sel, rf_we, alu_op,
//                 wb_sel, halted, illegal out)
// Build option: define SISC_CTRL_SWP_EN to implement SWP (two-cycle
// writeback through WB2); otherwise SWP decodes as an illegal opcode.
// -----------------------------------------------------------------------------
module sisc_ctrl_mc
   import sisc_pkg::*;
#(
   parameter int OP_W   = 4,
   parameter int STAT_W = 4,
   parameter int IMM_MM = IMM_MM_DEF
)(
   input  logic           clk,
   input  logic           rst_f,
   sisc_ctrl_mc_if.master bus
);

   state_t state_reg, state_next;

   logic is_noop, is_lod, is_str, is_swp, is_alu, is_hlt;
   logic is_abs_br, is_rel_br, is_branch, is_swp_en, is_legal;
   logic br_taken;

   assign is_noop   = (bus.opcode == OP_W'(OPC_NOOP));
   assign is_lod    = (bus.opcode == OP_W'(OPC_LOD));
   assign is_str    = (bus.opcode == OP_W'(OPC_STR));
   assign is_swp    = (bus.opcode == OP_W'(OPC_SWP));
   assign is_alu    = (bus.opcode == OP_W'(OPC_ALU));
   assign is_hlt    = (bus.opcode == OP_W'(OPC_HLT));
   assign is_abs_br = (bus.opcode == OP_W'(OPC_BRA)) || (bus.opcode == OP_W'(OPC_BNE));
   assign is_rel_br = (bus.opcode == OP_W'(OPC_BRR)) || (bus.opcode == OP_W'(OPC_BNR));
   assign is_branch = is_abs_br | is_rel_br;

`ifdef SISC_CTRL_SWP_EN
   assign is_swp_en = is_swp;
`else
   // SWP falls into the illegal class; WB2 is never entered.
   assign is_swp_en = 1'b0;
`endif

   assign is_legal = is_noop | is_lod | is_str | is_swp_en | is_alu | is_hlt | is_branch;

   sisc_br_cond #(
      .OP_W   (OP_W),
      .STAT_W (STAT_W)
   ) u_br_cond (
      .opcode (bus.opcode),
      .mm     (bus.mm),
      .stat   (bus.stat),
      .taken  (br_taken)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst_f)
         state_reg <= S_START0;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_START0:  state_next = S_START1;
         S_START1:  state_next = S_FETCH;
         S_FETCH:   if (bus.mem_rdy) state_next = S_DECODE;
         S_DECODE: begin
            if (is_branch)
               state_next = S_FETCH;
            else if (is_hlt)
               state_next = S_HALT;
            else if (is_lod | is_str | is_alu | is_swp_en)
               state_next = S_EXECUTE;
            else
               state_next = S_FETCH;       // NOOP and illegal opcodes
         end
         S_EXECUTE: state_next = (is_lod | is_str) ? S_MEM : S_WB;
         S_MEM:     if (bus.mem_rdy) state_next = is_lod ? S_WB : S_FETCH;
         S_WB:      state_next = is_swp_en ? S_WB2 : S_FETCH;
         S_WB2:     state_next = S_FETCH;
         S_HALT:    state_next = S_HALT;
         default:   state_next = S_START0;
      endcase
   end

   // Output logic
   always_comb begin
      bus.mem_req  = 1'b0;
      bus.dm_we    = 1'b0;
      bus.ir_load  = 1'b0;
      bus.pc_write = 1'b0;
      bus.pc_sel   = PC_INC;
      bus.rf_we    = 1'b0;
      bus.alu_op   = 2'b00;
      bus.wb_sel   = WB_ALU;
      bus.halted   = 1'b0;
      bus.illegal  = 1'b0;
      case (state_reg)
         S_FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_rdy) begin
               bus.ir_load  = 1'b1;
               bus.pc_write = 1'b1;
               bus.pc_sel   = PC_INC;
            end
         end
         S_DECODE: begin
            if (is_branch && br_taken) begin
               bus.pc_write = 1'b1;
               bus.pc_sel   = is_abs_br ? PC_ABS : PC_REL;
            end
            bus.illegal = ~is_legal;
         end
         S_EXECUTE: begin
            // bit1: status not saved for anything but ALU_OP
            bus.alu_op = {~is_alu, (bus.mm == STAT_W'(IMM_MM))};
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.dm_we   = is_str;
         end
         S_WB: begin
            bus.rf_we = 1'b1;
            if (is_lod)
               bus.wb_sel = WB_MEM;
            else if (is_swp_en)
               bus.wb_sel = WB_SWP;
            else
               bus.wb_sel = WB_ALU;
         end
         S_WB2: begin
            bus.rf_we  = 1'b1;
            bus.wb_sel = WB_ALU;
         end
         S_HALT: bus.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_sisc_ctrl_mc
// Directed testbench for sisc_ctrl_mc. Each task walks one instruction (or
// scenario) cycle by cycle, drives mem_rdy/opcode/mm/stat just after the
// rising edge and compares the packed output vector against hand-computed
// values. Output vector layout (MSB..LSB):
//   mem_req dm_we ir_load pc_write pc_sel[1:0] rf_we alu_op[1:0] wb_sel[1:0]
//   halted illegal
// -----------------------------------------------------------------------------
module tb_sisc_ctrl_mc;
   import sisc_pkg::*;

   logic clk = 1'b0;
   logic rst_f;
   always #5 clk = ~clk;

   sisc_ctrl_mc_if #(.OP_W(4), .STAT_W(4)) bus ();

   sisc_ctrl_mc #(.OP_W(4), .STAT_W(4), .IMM_MM(8)) dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
   );

   logic [12:0] outs;
   assign outs = {bus.mem_req, bus.dm_we, bus.ir_load, bus.pc_write, bus.pc_sel,
                  bus.rf_we, bus.alu_op, bus.wb_sel, bus.halted, bus.illegal};

   int checks = 0;
   int errors = 0;

   logic [12:0] f_rdy, f_wait;

   function automatic logic [12:0] ov(input logic mreq, input logic we, input logic irl,
                                      input logic pcw, input logic [1:0] psel,
                                      input logic rfw, input logic [1:0] aop,
                                      input logic [1:0] wsel, input logic hlt,
                                      input logic ill);
      return {mreq, we, irl, pcw, psel, rfw, aop, wsel, hlt, ill};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_f = 1'b1;
      bus.mem_rdy = 1'b0; bus.opcode = 4'd0; bus.mm = 4'd0; bus.stat = 4'd0;
      tick; tick;
      #1; checks++;
      if (outs !== 13'd0) begin
         errors++; $display("FAIL reset_start0 outs=%b expected=%b", outs, 13'd0);
      end
      rst_f = 1'b0;
      tick; #1; checks++;
      if (outs !== 13'd0) begin
         errors++; $display("FAIL reset_start1 outs=%b expected=%b", outs, 13'd0);
      end
      tick; #1; checks++;
      if (outs !== f_wait) begin
         errors++; $display("FAIL reset_first_fetch outs=%b expected=%b", outs, f_wait);
      end
      $display("reset: START0, START1, FETCH after 2 cycles");
   endtask

   task automatic test_alu;
      logic [12:0] exp_a [5];
      bit          rdy_a [5];
      bus.opcode = OPC_ALU; bus.mm = 4'd8; bus.stat = 4'd0;
      rdy_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_a = '{f_rdy, 13'd0, ov(0,0,0,0,2'd0,0,2'b01,2'd0,0,0),
                ov(0,0,0,0,2'd0,1,2'b00,2'd0,0,0), f_wait};
      for (int i = 0; i < 5; i++) begin
         bus.mem_rdy = rdy_a[i]; #1; checks++;
         if (outs !== exp_a[i]) begin
            errors++; $display("FAIL alu_op cyc%0d outs=%b expected=%b", i, outs, exp_a[i]);
         end
         tick;
      end
      $display("alu_op: imm mm=8, 4 cycles");
   endtask

   task automatic test_branch;
      logic [3:0]  op_a  [5];
      logic [3:0]  st_a  [5];
      logic [3:0]  mm_a  [5];
      logic [12:0] dec_a [5];
      op_a  = '{OPC_BRR, OPC_BNE, OPC_BRA, OPC_BNR, OPC_BRA};
      st_a  = '{4'b0010, 4'b0010, 4'b1000, 4'b0100, 4'b0100};
      mm_a  = '{4'b0010, 4'b0010, 4'b1001, 4'b0011, 4'b0011};
      dec_a = '{ov(0,0,0,1,2'd2,0,2'd0,2'd0,0,0), 13'd0,
                ov(0,0,0,1,2'd1,0,2'd0,2'd0,0,0),
                ov(0,0,0,1,2'd2,0,2'd0,2'd0,0,0), 13'd0};
      for (int k = 0; k < 5; k++) begin
         bus.opcode = op_a[k]; bus.stat = st_a[k]; bus.mm = mm_a[k];
         bus.mem_rdy = 1'b1; #1; checks++;
         if (outs !== f_rdy) begin
            errors++; $display("FAIL branch%0d_fetch outs=%b expected=%b", k, outs, f_rdy);
         end
         tick;
         bus.mem_rdy = 1'b0; #1; checks++;
         if (outs !== dec_a[k]) begin
            errors++; $display("FAIL branch%0d_decode outs=%b expected=%b", k, outs, dec_a[k]);
         end
         tick;
         #1; checks++;
         if (outs !== f_wait) begin
            errors++; $display("FAIL branch%0d_refetch outs=%b expected=%b", k, outs, f_wait);
         end
         $display("branch op=%0d stat=%b mm=%b decode=%b", op_a[k], st_a[k], mm_a[k], outs);
      end
   endtask

   task automatic test_lod_wait;
      logic [12:0] exp_a [8];
      bit          rdy_a [8];
      logic [12:0] mreq;
      mreq = ov(1,0,0,0,2'd0,0,2'd0,2'd0,0,0);
      bus.opcode = OPC_LOD; bus.mm = 4'd0; bus.stat = 4'd0;
      // mem_rdy high in DECODE/EXECUTE/WB must be ignored
      rdy_a = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_a = '{f_rdy, 13'd0, ov(0,0,0,0,2'd0,0,2'b10,2'd0,0,0), mreq, mreq, mreq,
                ov(0,0,0,0,2'd0,1,2'd0,2'd1,0,0), f_wait};
      for (int i = 0; i < 8; i++) begin
         bus.mem_rdy = rdy_a[i]; #1; checks++;
         if (outs !== exp_a[i]) begin
            errors++; $display("FAIL lod_wait cyc%0d outs=%b expected=%b", i, outs, exp_a[i]);
         end
         tick;
      end
      $display("lod: mem_req held 3 cycles, wb_sel=1");
   endtask

   task automatic test_str_reset;
      logic [12:0] exp_a [4];
      bit          rdy_a [4];
      bus.opcode = OPC_STR; bus.mm = 4'd0; bus.stat = 4'd0;
      rdy_a = '{1'b1, 1'b0, 1'b0, 1'b0};
      exp_a = '{f_rdy, 13'd0, ov(0,0,0,0,2'd0,0,2'b10,2'd0,0,0),
                ov(1,1,0,0,2'd0,0,2'd0,2'd0,0,0)};
      for (int i = 0; i < 4; i++) begin
         bus.mem_rdy = rdy_a[i]; #1; checks++;
         if (outs !== exp_a[i]) begin
            errors++; $display("FAIL str cyc%0d outs=%b expected=%b", i, outs, exp_a[i]);
         end
         if (i == 3) rst_f = 1'b1;
         tick;
      end
      #1; checks++;
      if (outs !== 13'd0) begin
         errors++; $display("FAIL str_reset_start0 outs=%b expected=%b", outs, 13'd0);
      end
      rst_f = 1'b0;
      tick; #1; checks++;
      if (outs !== 13'd0) begin
         errors++; $display("FAIL str_reset_start1 outs=%b expected=%b", outs, 13'd0);
      end
      tick; #1; checks++;
      if (outs !== f_wait) begin
         errors++; $display("FAIL str_reset_fetch outs=%b expected=%b", outs, f_wait);
      end
      $display("str: reset mid-MEM drops mem_req/dm_we");
   endtask

   task automatic test_swp;
`ifdef SISC_CTRL_SWP_EN
      logic [12:0] exp_a [6];
      bit          rdy_a [6];
      bus.opcode = OPC_SWP; bus.mm = 4'd8; bus.stat = 4'd0;
      rdy_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_a = '{f_rdy, 13'd0, ov(0,0,0,0,2'd0,0,2'b11,2'd0,0,0),
                ov(0,0,0,0,2'd0,1,2'd0,2'd2,0,0), ov(0,0,0,0,2'd0,1,2'd0,2'd0,0,0), f_wait};
      for (int i = 0; i < 6; i++) begin
`else
      logic [12:0] exp_a [3];
      bit          rdy_a [3];
      bus.opcode = OPC_SWP; bus.mm = 4'd8; bus.stat = 4'd0;
      rdy_a = '{1'b1, 1'b0, 1'b0};
      exp_a = '{f_rdy, ov(0,0,0,0,2'd0,0,2'd0,2'd0,0,1), f_wait};
      for (int i = 0; i < 3; i++) begin
`endif
         bus.mem_rdy = rdy_a[i]; #1; checks++;
         if (outs !== exp_a[i]) begin
            errors++; $display("FAIL swp cyc%0d outs=%b expected=%b", i, outs, exp_a[i]);
         end
         tick;
      end
      $display("swp: sequence checked");
   endtask

   task automatic test_illegal;
      logic [3:0] op_a [4];
      logic [12:0] dec;
      op_a = '{4'd0, 4'd9, 4'd12, 4'd14};
      bus.mm = 4'd0; bus.stat = 4'd0;
      for (int k = 0; k < 4; k++) begin
         bus.opcode = op_a[k];
         dec = ov(0,0,0,0,2'd0,0,2'd0,2'd0,0,(op_a[k] != 4'd0));
         bus.mem_rdy = 1'b1; #1; checks++;
         if (outs !== f_rdy) begin
            errors++; $display("FAIL ill%0d_fetch outs=%b expected=%b", k, outs, f_rdy);
         end
         tick;
         bus.mem_rdy = 1'b0; #1; checks++;
         if (outs !== dec) begin
            errors++; $display("FAIL ill%0d_decode outs=%b expected=%b", k, outs, dec);
         end
         tick;
         #1; checks++;
         if (outs !== f_wait) begin
            errors++; $display("FAIL ill%0d_after outs=%b expected=%b", k, outs, f_wait);
         end
         $display("opcode %0d: decode=%b, back to FETCH", op_a[k], dec);
      end
   endtask

   task automatic test_halt;
      logic [12:0] hv;
      hv = ov(0,0,0,0,2'd0,0,2'd0,2'd0,1,0);
      bus.opcode = OPC_HLT; bus.mm = 4'd0; bus.stat = 4'd0;
      bus.mem_rdy = 1'b1; #1; checks++;
      if (outs !== f_rdy) begin
         errors++; $display("FAIL hlt_fetch outs=%b expected=%b", outs, f_rdy);
      end
      tick;
      bus.mem_rdy = 1'b0; #1; checks++;
      if (outs !== 13'd0) begin
         errors++; $display("FAIL hlt_decode outs=%b expected=%b", outs, 13'd0);
      end
      tick;
      for (int i = 0; i < 10; i++) begin
         bus.mem_rdy = i[0]; #1; checks++;
         if (outs !== hv) begin
            errors++; $display("FAIL hlt_hold cyc%0d outs=%b expected=%b", i, outs, hv);
         end
         tick;
      end
      rst_f = 1'b1;
      tick; #1; checks++;
      if (outs !== 13'd0) begin
         errors++; $display("FAIL hlt_reset outs=%b expected=%b", outs, 13'd0);
      end
      rst_f = 1'b0;
      $display("hlt: halted held 10 cycles, cleared by reset");
   endtask

   initial begin
      f_rdy  = ov(1,0,1,1,2'd0,0,2'd0,2'd0,0,0);
      f_wait = ov(1,0,0,0,2'd0,0,2'd0,2'd0,0,0);
      test_reset;
      test_alu;
      test_branch;
      test_lod_wait;
      test_str_reset;
      test_swp;
      test_illegal;
      test_halt;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sisc_ctrl_mc.md
SISC_CTRL_MC -- requirements
Module: sisc_ctrl_mc

Interface
REQ-001 Parameter OP_W, default 4, opcode width.
REQ-002 Parameter STAT_W, default 4, status/condition-mask width; mm width equals STAT_W.
REQ-003 Parameter IMM_MM, default 8, mm value selecting the immediate operand.
REQ-004 Port clk  input  1  system clock, rising edge active; the single clock.
REQ-005 Port rst_f  input  1  reset, synchronous, active-high.
REQ-006 Port opcode  input  OP_W  instruction opcode from the IR, stable after ir_load.
REQ-007 Port mm  input  STAT_W  addressing mode / branch condition mask.
REQ-008 Port stat  input  STAT_W  status register contents.
REQ-009 Port mem_rdy  input  1  memory completion strobe for the current mem_req.
REQ-010 Port mem_req  output  1  memory access request, held until mem_rdy.
REQ-011 Port dm_we  output  1  data memory write strobe, valid with mem_req.
REQ-012 Port ir_load  output  1  load IR from memory data.
REQ-013 Port pc_write  output  1  update PC.
REQ-014 Port pc_sel  output  2  PC source: 0 = PC+1, 1 = absolute target, 2 = PC-relative target.
REQ-015 Port rf_we  output  1  register file write enable.
REQ-016 Port alu_op  output  2  bit1 = non-arithmetic (status not saved), bit0 = immediate operand.
REQ-017 Port wb_sel  output  2  writeback source: 0 = ALU, 1 = memory, 2 = swap operand.
REQ-018 Port halted  output  1  high while in HALT.
REQ-019 Port illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-020 States SHALL be START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, WB2, HALT.
REQ-021 Outputs SHALL be combinational from the present state and the opcode, mm and stat inputs; all outputs not listed for a state SHALL be 0.
REQ-022 START0 SHALL go to START1, and START1 SHALL go to FETCH unconditionally.
REQ-023 FETCH SHALL assert mem_req; on mem_rdy it SHALL assert ir_load and pc_write with pc_sel=0 and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-024 DECODE branch handling: BRA and BRR are taken when (stat & mm) != 0; BNE and BNR are taken when (stat & mm) == 0.
REQ-025 DECODE on a taken branch SHALL assert pc_write with pc_sel=1 (BRA/BNE) or 2 (BRR/BNR); every branch SHALL go to FETCH.
REQ-026 DECODE SHALL go to HALT on HLT, to FETCH on NOOP, and to EXECUTE on LOD, STR, SWP or ALU_OP.
REQ-027 Opcodes 9-14 SHALL be treated as NOOP and SHALL pulse illegal in DECODE.
REQ-028 EXECUTE SHALL drive alu_op[1]=0 for ALU_OP and 1 otherwise, and alu_op[0]=(mm==IMM_MM).
REQ-029 EXECUTE SHALL go to MEM for LOD/STR and to WB for ALU_OP/SWP.
REQ-030 MEM SHALL assert mem_req, plus dm_we for STR, and hold until mem_rdy; it SHALL then go to WB (LOD) or FETCH (STR).
REQ-031 WB SHALL assert rf_we with wb_sel=1 for LOD, 0 for ALU_OP and 2 for SWP; it SHALL go to WB2 for SWP and to FETCH otherwise.
REQ-032 WB2 SHALL assert rf_we with wb_sel=0 and go to FETCH.
REQ-033 HALT SHALL be absorbing until reset and SHALL assert halted; it SHALL NOT assert mem_req or pc_write.
REQ-034 mem_rdy outside FETCH/MEM SHALL be ignored.

Reset
REQ-035 rst_f high at a rising clk edge SHALL force START0 from any state, including mid-MEM, WB2 or HALT.
REQ-036 In START0 all outputs SHALL be 0; an outstanding mem_req SHALL drop without waiting for mem_rdy.
REQ-037 The first FETCH SHALL occur 2 cycles after rst_f deasserts.

Configuration
REQ-038 With SISC_CTRL_SWP_EN defined, SWP SHALL follow REQ-029/031/032.
REQ-039 Without SISC_CTRL_SWP_EN, SWP SHALL decode as illegal (REQ-027), and WB2 SHALL be unreachable and may be omitted.

Structure
REQ-040 A shared package sisc_pkg SHALL hold the state encoding, the opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15), the pc_sel and wb_sel codes, and the IMM_MM default.
REQ-041 Branch evaluation SHALL be one sub-module, sisc_br_cond (opcode, mm, stat -> taken).

Verification
REQ-042 Reset, then ALU_OP with mm=8 and mem_rdy immediate: FETCH, DECODE, EXECUTE (alu_op=01), WB (rf_we=1, wb_sel=0); 4 cycles per instruction.
REQ-043 BRR with stat=4'b0010 and mm=4'b0010: DECODE asserts pc_write with pc_sel=2. BNE with the same values: no pc_write.
REQ-044 LOD with mem_rdy delayed 3 cycles in MEM: mem_req held 3 cycles; WB follows with wb_sel=1.
REQ-045 STR with rst_f pulsed while in MEM: next state START0, mem_req=0 and dm_we=0 that cycle.
REQ-046 SWP with macro: WB (wb_sel=2), then WB2 (wb_sel=0). Without macro: illegal=1 and return to FETCH.
REQ-047 HLT: halted=1 and held for 10 cycles; opcode 12: illegal pulse of exactly 1 cycle.
